// File: rtl/mem_stage.sv
// Data-memory access stage; loads/stores a word-addressed memory at byte base 1024.
// Define MEM_STAGE_WAIT_EN for the multi-cycle IDLE/BUSY/DONE access with freeze.
module mem_stage #(
    parameter int WAIT_CYCLES = 3,
    parameter int MEM_DEPTH   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_en_in,
    input  logic        MEM_r_en_in,
    input  logic        MEM_w_en_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_Rm_in,
    output logic        WB_en_out,
    output logic        MEM_r_en_out,
    output logic [3:0]  dest_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] data_mem_out,
    output logic        freeze
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [31:0]   mem [MEM_DEPTH];
    logic [31:0]   word_addr;
    logic [AW-1:0] idx;
    logic          req;
    logic          mem_we;
    logic          rd_valid;
    logic          unused_ok;

    // Out-of-window addresses simply wrap onto the low index bits
    assign word_addr = alu_res_in - 32'd1024;
    assign idx       = word_addr[AW+1:2];
    assign req       = MEM_r_en_in | MEM_w_en_in;

`ifdef MEM_STAGE_WAIT_EN
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Store commits on the edge leaving DONE, so a load+store reads the old word
    assign freeze    = req & (state != DONE);
    assign mem_we    = (state == DONE) & MEM_w_en_in;
    assign rd_valid  = (state == DONE) & MEM_r_en_in;
    assign unused_ok = ^{word_addr[31:AW+2], word_addr[1:0]};
`else
    assign freeze    = 1'b0;
    assign mem_we    = MEM_w_en_in;
    assign rd_valid  = MEM_r_en_in;
    assign unused_ok = ^{word_addr[31:AW+2], word_addr[1:0], rst, req};
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= val_Rm_in;
        end
    end

    assign WB_en_out    = WB_en_in & ~freeze;
    assign MEM_r_en_out = MEM_r_en_in & ~freeze;
    assign dest_out     = dest_in;
    assign alu_res_out  = alu_res_in;
    assign data_mem_out = rd_valid ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard testbench for mem_stage; covers both the wait-state and
// the single-cycle build selected by MEM_STAGE_WAIT_EN.
module tb_mem_stage;

    localparam int WAIT_CYCLES = 3;
    localparam int MEM_DEPTH   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en_in;
    logic        MEM_r_en_in;
    logic        MEM_w_en_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_res_in;
    logic [31:0] val_Rm_in;
    logic        WB_en_out;
    logic        MEM_r_en_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_res_out;
    logic [31:0] data_mem_out;
    logic        freeze;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] model [MEM_DEPTH];
    logic [31:0] exp_q [$];

    mem_stage #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .MEM_DEPTH  (MEM_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .WB_en_in    (WB_en_in),
        .MEM_r_en_in (MEM_r_en_in),
        .MEM_w_en_in (MEM_w_en_in),
        .dest_in     (dest_in),
        .alu_res_in  (alu_res_in),
        .val_Rm_in   (val_Rm_in),
        .WB_en_out   (WB_en_out),
        .MEM_r_en_out(MEM_r_en_out),
        .dest_out    (dest_out),
        .alu_res_out (alu_res_out),
        .data_mem_out(data_mem_out),
        .freeze      (freeze)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int widx(input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'd1024) >> 2;
        return int'(w % MEM_DEPTH);
    endfunction

    task automatic set_in(input logic r, input logic w, input logic wb,
                          input logic [31:0] addr, input logic [31:0] data);
        MEM_r_en_in = r;
        MEM_w_en_in = w;
        WB_en_in    = wb;
        dest_in     = 4'(widx(addr));
        alu_res_in  = addr;
        val_Rm_in   = data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0);
        #12;
        checks++;
        if (freeze !== 1'b0 || data_mem_out !== 32'h0 ||
            WB_en_out !== 1'b1 || MEM_r_en_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: fz=%b data=%h wb=%b rd=%b required 0 0 1 0",
                     freeze, data_mem_out, WB_en_out, MEM_r_en_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (freeze !== 1'b0 || data_mem_out !== 32'h0 || WB_en_out !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: fz=%b data=%h wb=%b required 0 0 1",
                     freeze, data_mem_out, WB_en_out);
        end
        WB_en_in = 1'b0;
    endtask

`ifdef MEM_STAGE_WAIT_EN
    // One full access; called just after a posedge, returns just after one
    task automatic access(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, input bit drive,
                          output int done_cyc);
        int  fz;
        bit  done;
        int  ix;
        logic wb;
        logic [31:0] exp_d;
        fz = 0;
        done = 0;
        done_cyc = -1;
        ix = widx(addr);
        wb = r & ~w;
        if (r) exp_q.push_back(model[ix]);
        if (drive) set_in(r, w, wb, addr, data);
        for (int i = 0; i < WAIT_CYCLES + 6 && !done; i++) begin
            @(negedge clk);
            if (freeze) begin
                fz++;
                checks++;
                if (WB_en_out !== 1'b0 || MEM_r_en_out !== 1'b0 || data_mem_out !== 32'h0) begin
                    errors++;
                    $display("FAIL bubble: wb=%b rd=%b data=%h required 0 0 0",
                             WB_en_out, MEM_r_en_out, data_mem_out);
                end
            end else begin
                done = 1;
                done_cyc = cyc;
                checks++;
                if (fz != WAIT_CYCLES + 1) begin
                    errors++;
                    $display("FAIL freeze_len addr=%0d: got %0d required %0d",
                             addr, fz, WAIT_CYCLES + 1);
                end
                checks++;
                if (WB_en_out !== wb || MEM_r_en_out !== r ||
                    dest_out !== dest_in || alu_res_out !== addr) begin
                    errors++;
                    $display("FAIL done_ctl: wb=%b rd=%b dest=%h alu=%h required %b %b %h %h",
                             WB_en_out, MEM_r_en_out, dest_out, alu_res_out,
                             wb, r, dest_in, addr);
                end
                exp_d = r ? exp_q.pop_front() : 32'h0;
                checks++;
                if (data_mem_out !== exp_d) begin
                    errors++;
                    $display("FAIL done_data addr=%0d: got %h required %h",
                             addr, data_mem_out, exp_d);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%0d: no DONE within %0d cycles required done",
                     addr, WAIT_CYCLES + 6);
            if (r && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (w) model[ix] = data;
        set_in(1'b0, 1'b0, 1'b0, addr, data);
    endtask

    task automatic test_store_load;
        int d;
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1, d);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, d);
    endtask

    task automatic test_wrap;
        int d;
        access(1'b0, 1'b1, 32'd1024 + 32'd4 * MEM_DEPTH, 32'h1, 1'b1, d);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, d);
    endtask

    task automatic test_load_store_both;
        int d;
        access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b1, d);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, d);
    endtask

    task automatic test_drop;
        int d;
        access(1'b0, 1'b1, 32'd1040, 32'hA5A5A5A5, 1'b1, d);
        set_in(1'b0, 1'b1, 1'b0, 32'd1040, 32'h5A5A5A5A);
        repeat (2) @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 32'd1040, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (freeze !== 1'b0) begin
                errors++;
                $display("FAIL drop_freeze: got %b required 0", freeze);
            end
        end
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b1, d);
    endtask

    task automatic test_reset_abort;
        int d;
        access(1'b0, 1'b1, 32'd1032, 32'h12345678, 1'b1, d);
        set_in(1'b0, 1'b1, 1'b0, 32'd1032, 32'hBAD0BAD0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (freeze !== 1'b1 || data_mem_out !== 32'h0 || WB_en_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: fz=%b data=%h wb=%b required 1 0 0",
                     freeze, data_mem_out, WB_en_out);
        end
        rst = 1'b0;
        // State must be IDLE now, so this load takes the full latency
        set_in(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, d);
    endtask

    task automatic test_back_to_back;
        int d0;
        int d1;
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, d0);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, d1);
        checks++;
        if (d1 - d0 != WAIT_CYCLES + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required %0d", d1 - d0, WAIT_CYCLES + 2);
        end
    endtask

    task automatic test_random;
        int d;
        logic [31:0] a;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            a = 32'd1024 + 32'd4 * 32'($urandom_range(0, MEM_DEPTH - 1));
            v = $urandom;
            access(1'b0, 1'b1, a, v, 1'b1, d);
            access(1'b1, 1'b0, a, 32'h0, 1'b1, d);
        end
    endtask
`else
    // One single-cycle access; called just after a posedge
    task automatic nw_cycle(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] data);
        int ix;
        logic wb;
        logic [31:0] exp_d;
        ix = widx(addr);
        wb = r & ~w;
        if (r) exp_q.push_back(model[ix]);
        set_in(r, w, wb, addr, data);
        @(negedge clk);
        checks++;
        if (freeze !== 1'b0 || WB_en_out !== wb || MEM_r_en_out !== r ||
            dest_out !== dest_in || alu_res_out !== addr) begin
            errors++;
            $display("FAIL nw_ctl: fz=%b wb=%b rd=%b dest=%h alu=%h required 0 %b %b %h %h",
                     freeze, WB_en_out, MEM_r_en_out, dest_out, alu_res_out,
                     wb, r, dest_in, addr);
        end
        exp_d = r ? exp_q.pop_front() : 32'h0;
        checks++;
        if (data_mem_out !== exp_d) begin
            errors++;
            $display("FAIL nw_data addr=%0d: got %h required %h", addr, data_mem_out, exp_d);
        end
        @(posedge clk);
        #1;
        if (w) model[ix] = data;
    endtask

    task automatic test_nowait;
        logic [31:0] a;
        logic [31:0] v;
        nw_cycle(1'b0, 1'b1, 32'd1036, 32'h0BADF00D);
        nw_cycle(1'b1, 1'b0, 32'd1036, 32'h0);
        nw_cycle(1'b0, 1'b1, 32'd1024 + 32'd4 * MEM_DEPTH, 32'h1);
        nw_cycle(1'b1, 1'b0, 32'd1024, 32'h0);
        nw_cycle(1'b1, 1'b1, 32'd1036, 32'h77777777);
        nw_cycle(1'b1, 1'b0, 32'd1036, 32'h0);
        for (int i = 0; i < 4; i++) begin
            a = 32'd1024 + 32'd4 * 32'($urandom_range(0, MEM_DEPTH - 1));
            v = $urandom;
            nw_cycle(1'b0, 1'b1, a, v);
            nw_cycle(1'b1, 1'b0, a, 32'h0);
        end
        nw_cycle(1'b0, 1'b0, 32'd1036, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
`ifdef MEM_STAGE_WAIT_EN
        test_store_load();
        test_wrap();
        test_load_store_both();
        test_drop();
        test_reset_abort();
        test_back_to_back();
        test_random();
`else
        test_nowait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
